// File: rtl/regfile_pkg.sv
// Shared constants and types for the parametrised register file.
// Holds default geometry, the clear-sequencer state type and the hardwired-zero index.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam int ZERO_REG = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks r1..r(2**ADDR_W-1), zeroing one register per cycle.
// Latency: busy rises one edge after clr_req and stays high 2**ADDR_W-1 cycles.
// Backpressure: none; clr_req seen while busy is ignored.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    clr_state_t        state;
    clr_state_t        state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Terminal index is compared explicitly so the walk never depends on the counter wrapping.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = ADDR_W'(1);
                end
            end
            CLEAR: begin
                if (cnt == LAST_IDX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_en   = busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_param.sv
// Register file: NUM_RD zero-latency read ports, one clocked write port, r0 reads zero.
// Latency: reads combinational, writes visible after the edge; writes dropped while busy.
// Backpressure: none. Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module reg_file_param
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    assign wr_ok = we && !busy && (waddr != ZERO_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_en) begin
            regs[clr_addr] <= '0;
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        assign idx = raddr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign rdata[k*DATA_W +: DATA_W] = (idx == ZERO_IDX)          ? '0    :
                                           (wr_ok && (idx == waddr))  ? wdata :
                                                                        regs[idx];
`else
        assign rdata[k*DATA_W +: DATA_W] = (idx == ZERO_IDX) ? '0 : regs[idx];
`endif
    end

endmodule
